// File: rtl/active_list_recovery_sequencer_if.sv
// Recovery-manager <-> active-list tail rollback handshake bundle.
// The master side issues the recovery request and the slave side (the sequencer) drives the pops.
interface active_list_recovery_sequencer_if #(
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned AL_ENTRY_NUM   = 64,
  parameter int unsigned AL_COUNT_WIDTH = $clog2(AL_ENTRY_NUM + 1),
  parameter int unsigned POP_NUM_WIDTH  = $clog2(COMMIT_WIDTH + 1)
);
  logic                      recoveryStart;
  logic [AL_COUNT_WIDTH-1:0] recoveryEntryNum;
  logic                      rmtWriteReady;
  logic [POP_NUM_WIDTH-1:0]  popTailNum;
  logic [COMMIT_WIDTH-1:0]   popLaneValid;
  logic                      busy;
  logic                      recoveryDone;
  logic [AL_COUNT_WIDTH-1:0] remainingNum;
  logic                      protocolError;

  modport master (
    output recoveryStart, recoveryEntryNum, rmtWriteReady,
    input  popTailNum, popLaneValid, busy, recoveryDone, remainingNum, protocolError
  );

  modport slave (
    input  recoveryStart, recoveryEntryNum, rmtWriteReady,
    output popTailNum, popLaneValid, busy, recoveryDone, remainingNum, protocolError
  );
endinterface

// File: rtl/active_list_recovery_sequencer.sv
// Rolls back the active-list tail after a misprediction/exception, popping up to
// COMMIT_WIDTH flushed entries per cycle while rename is held stalled.
module active_list_recovery_sequencer #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned AL_ENTRY_NUM = 64
) (
  input logic                               clk,
  input logic                               rst,
  active_list_recovery_sequencer_if.slave   bus
);
  localparam int unsigned AL_COUNT_WIDTH = $clog2(AL_ENTRY_NUM + 1);
  localparam int unsigned POP_NUM_WIDTH  = $clog2(COMMIT_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [AL_COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                      error_q, error_d;

  logic [POP_NUM_WIDTH-1:0]  pop_num_c;
  logic [COMMIT_WIDTH-1:0]   lane_valid_c;
  logic                      busy_c;
  logic                      done_c;

  // State, remaining count and sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.recoveryStart) begin
          if (bus.recoveryEntryNum > AL_COUNT_WIDTH'(AL_ENTRY_NUM)) begin
            // Oversized request: flag it but still flush the whole list
            error_d     = 1'b1;
            remaining_d = AL_COUNT_WIDTH'(AL_ENTRY_NUM);
            state_d     = S_WALK;
          end else if (bus.recoveryEntryNum == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = bus.recoveryEntryNum;
            state_d     = S_WALK;
          end
        end
      end
      S_WALK: begin
        if (bus.recoveryStart) error_d = 1'b1;
        remaining_d = remaining_q - AL_COUNT_WIDTH'(pop_num_c);
        if (remaining_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.recoveryStart) error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Output decode; pop count follows rmtWriteReady in the same cycle
  always_comb begin
    pop_num_c    = '0;
    lane_valid_c = '0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      S_IDLE: busy_c = bus.recoveryStart;
      S_WALK: begin
        busy_c = 1'b1;
        if (bus.rmtWriteReady) begin
          if (remaining_q < AL_COUNT_WIDTH'(COMMIT_WIDTH)) begin
            pop_num_c = POP_NUM_WIDTH'(remaining_q);
          end else begin
            pop_num_c = POP_NUM_WIDTH'(COMMIT_WIDTH);
          end
        end
      end
      S_DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      lane_valid_c[i] = (POP_NUM_WIDTH'(i) < pop_num_c);
    end
  end

  assign bus.popTailNum    = pop_num_c;
  assign bus.popLaneValid  = lane_valid_c;
  assign bus.busy          = busy_c;
  assign bus.recoveryDone  = done_c;
  assign bus.remainingNum  = remaining_q;
  assign bus.protocolError = error_q;

endmodule

// File: tb/tb_active_list_recovery_sequencer.sv
// Directed bench for the active-list tail rollback sequencer (COMMIT_WIDTH=2, 64 entries).
module tb_active_list_recovery_sequencer;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  active_list_recovery_sequencer_if bif ();

  active_list_recovery_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.recoveryStart    = 1'b0;
    bif.recoveryEntryNum = '0;
    bif.rmtWriteReady    = 1'b1;
    @(negedge clk);
    checks++; if (bif.popTailNum !== 2'd0) begin errors++; $display("FAIL reset_pop got=%0d exp=0", bif.popTailNum); end
    checks++; if (bif.popLaneValid !== 2'b00) begin errors++; $display("FAIL reset_lane got=%b exp=00", bif.popLaneValid); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
    checks++; if (bif.recoveryDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bif.recoveryDone); end
    checks++; if (bif.remainingNum !== 7'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", bif.remainingNum); end
    checks++; if (bif.protocolError !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bif.protocolError); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  // E=5, always ready: pops 2,2,1 then done
  task automatic test_basic();
    logic [1:0] ep [6] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    logic [1:0] el [6] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [6:0] er [6] = '{7'd0, 7'd5, 7'd3, 7'd1, 7'd0, 7'd0};
    logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      bif.recoveryStart    = (c == 0);
      bif.recoveryEntryNum = 7'd5;
      bif.rmtWriteReady    = 1'b1;
      @(negedge clk);
      checks++; if (bif.popTailNum !== ep[c]) begin errors++; $display("FAIL basic_pop c=%0d got=%0d exp=%0d", c, bif.popTailNum, ep[c]); end
      checks++; if (bif.popLaneValid !== el[c]) begin errors++; $display("FAIL basic_lane c=%0d got=%b exp=%b", c, bif.popLaneValid, el[c]); end
      checks++; if (bif.remainingNum !== er[c]) begin errors++; $display("FAIL basic_rem c=%0d got=%0d exp=%0d", c, bif.remainingNum, er[c]); end
      checks++; if (bif.busy !== eb[c]) begin errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, bif.busy, eb[c]); end
      checks++; if (bif.recoveryDone !== ed[c]) begin errors++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, bif.recoveryDone, ed[c]); end
      tick();
    end
  endtask

  // E=0: straight to DONE
  task automatic test_zero();
    logic eb [3] = '{1'b1, 1'b1, 1'b0};
    logic ed [3] = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      bif.recoveryStart    = (c == 0);
      bif.recoveryEntryNum = 7'd0;
      bif.rmtWriteReady    = 1'b1;
      @(negedge clk);
      checks++; if (bif.popTailNum !== 2'd0) begin errors++; $display("FAIL zero_pop c=%0d got=%0d exp=0", c, bif.popTailNum); end
      checks++; if (bif.busy !== eb[c]) begin errors++; $display("FAIL zero_busy c=%0d got=%b exp=%b", c, bif.busy, eb[c]); end
      checks++; if (bif.recoveryDone !== ed[c]) begin errors++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, bif.recoveryDone, ed[c]); end
      tick();
    end
  endtask

  // E=4 with a one-cycle stall at N+2
  task automatic test_stall();
    logic       rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] ep  [6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [6:0] er  [6] = '{7'd0, 7'd4, 7'd2, 7'd2, 7'd0, 7'd0};
    logic       ed  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      bif.recoveryStart    = (c == 0);
      bif.recoveryEntryNum = 7'd4;
      bif.rmtWriteReady    = rdy[c];
      @(negedge clk);
      checks++; if (bif.popTailNum !== ep[c]) begin errors++; $display("FAIL stall_pop c=%0d got=%0d exp=%0d", c, bif.popTailNum, ep[c]); end
      checks++; if (bif.remainingNum !== er[c]) begin errors++; $display("FAIL stall_rem c=%0d got=%0d exp=%0d", c, bif.remainingNum, er[c]); end
      checks++; if (bif.recoveryDone !== ed[c]) begin errors++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, bif.recoveryDone, ed[c]); end
      tick();
    end
    bif.rmtWriteReady = 1'b1;
  endtask

  // E=64: 32 full-width pops, done at N+33
  task automatic test_full();
    logic [1:0] ep;
    logic [1:0] el;
    logic [6:0] er;
    for (int c = 0; c < 35; c++) begin
      bif.recoveryStart    = (c == 0);
      bif.recoveryEntryNum = 7'd64;
      bif.rmtWriteReady    = 1'b1;
      ep = (c >= 1 && c <= 32) ? 2'd2 : 2'd0;
      el = (c >= 1 && c <= 32) ? 2'b11 : 2'b00;
      er = (c >= 1 && c <= 33) ? 7'(64 - 2 * (c - 1)) : 7'd0;
      @(negedge clk);
      checks++; if (bif.popTailNum !== ep) begin errors++; $display("FAIL full_pop c=%0d got=%0d exp=%0d", c, bif.popTailNum, ep); end
      checks++; if (bif.popLaneValid !== el) begin errors++; $display("FAIL full_lane c=%0d got=%b exp=%b", c, bif.popLaneValid, el); end
      checks++; if (bif.remainingNum !== er) begin errors++; $display("FAIL full_rem c=%0d got=%0d exp=%0d", c, bif.remainingNum, er); end
      checks++; if (bif.busy !== (c <= 33)) begin errors++; $display("FAIL full_busy c=%0d got=%b exp=%b", c, bif.busy, (c <= 33)); end
      checks++; if (bif.recoveryDone !== (c == 33)) begin errors++; $display("FAIL full_done c=%0d got=%b exp=%b", c, bif.recoveryDone, (c == 33)); end
      tick();
    end
  endtask

  // New legal start in the IDLE cycle right after DONE
  task automatic test_back_to_back();
    logic       st  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0] en  [7] = '{7'd2, 7'd0, 7'd0, 7'd1, 7'd0, 7'd0, 7'd0};
    logic [1:0] ep  [7] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic       eb  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ed  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 7; c++) begin
      bif.recoveryStart    = st[c];
      bif.recoveryEntryNum = en[c];
      bif.rmtWriteReady    = 1'b1;
      @(negedge clk);
      checks++; if (bif.popTailNum !== ep[c]) begin errors++; $display("FAIL b2b_pop c=%0d got=%0d exp=%0d", c, bif.popTailNum, ep[c]); end
      checks++; if (bif.busy !== eb[c]) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, bif.busy, eb[c]); end
      checks++; if (bif.recoveryDone !== ed[c]) begin errors++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, bif.recoveryDone, ed[c]); end
      checks++; if (bif.protocolError !== 1'b0) begin errors++; $display("FAIL b2b_err c=%0d got=%b exp=0", c, bif.protocolError); end
      tick();
    end
  endtask

  // Second start mid-walk is ignored but latches protocolError
  task automatic test_start_in_walk();
    logic [1:0] ep [6] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [6:0] er [6] = '{7'd0, 7'd3, 7'd1, 7'd0, 7'd0, 7'd0};
    logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ee [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      bif.recoveryStart    = (c <= 1);
      bif.recoveryEntryNum = (c == 0) ? 7'd3 : 7'd1;
      bif.rmtWriteReady    = 1'b1;
      @(negedge clk);
      checks++; if (bif.popTailNum !== ep[c]) begin errors++; $display("FAIL walkstart_pop c=%0d got=%0d exp=%0d", c, bif.popTailNum, ep[c]); end
      checks++; if (bif.remainingNum !== er[c]) begin errors++; $display("FAIL walkstart_rem c=%0d got=%0d exp=%0d", c, bif.remainingNum, er[c]); end
      checks++; if (bif.recoveryDone !== ed[c]) begin errors++; $display("FAIL walkstart_done c=%0d got=%b exp=%b", c, bif.recoveryDone, ed[c]); end
      checks++; if (bif.protocolError !== ee[c]) begin errors++; $display("FAIL walkstart_err c=%0d got=%b exp=%b", c, bif.protocolError, ee[c]); end
      tick();
    end
  endtask

  // Async reset in the middle of a walk
  task automatic test_async_reset();
    bif.recoveryStart    = 1'b1;
    bif.recoveryEntryNum = 7'd6;
    bif.rmtWriteReady    = 1'b1;
    @(negedge clk);
    checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL areset_busy_start got=%b exp=1", bif.busy); end
    tick();
    bif.recoveryStart = 1'b0;
    @(negedge clk);
    checks++; if (bif.popTailNum !== 2'd2) begin errors++; $display("FAIL areset_pop1 got=%0d exp=2", bif.popTailNum); end
    tick();
    #1;
    checks++; if (bif.remainingNum !== 7'd4) begin errors++; $display("FAIL areset_rem2 got=%0d exp=4", bif.remainingNum); end
    checks++; if (bif.popTailNum !== 2'd2) begin errors++; $display("FAIL areset_pop2 got=%0d exp=2", bif.popTailNum); end
    rst = 1'b0;
    #1;
    checks++; if (bif.popTailNum !== 2'd0) begin errors++; $display("FAIL areset_pop_drop got=%0d exp=0", bif.popTailNum); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL areset_busy_drop got=%b exp=0", bif.busy); end
    checks++; if (bif.remainingNum !== 7'd0) begin errors++; $display("FAIL areset_rem_drop got=%0d exp=0", bif.remainingNum); end
    checks++; if (bif.protocolError !== 1'b0) begin errors++; $display("FAIL areset_err_clear got=%b exp=0", bif.protocolError); end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bif.recoveryDone !== 1'b0) begin errors++; $display("FAIL areset_done c=%0d got=%b exp=0", c, bif.recoveryDone); end
      checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL areset_idle_busy c=%0d got=%b exp=0", c, bif.busy); end
      checks++; if (bif.popTailNum !== 2'd0) begin errors++; $display("FAIL areset_idle_pop c=%0d got=%0d exp=0", c, bif.popTailNum); end
      tick();
    end
  endtask

  // Count above capacity: flagged and clamped to 64
  task automatic test_overflow();
    bif.recoveryStart    = 1'b1;
    bif.recoveryEntryNum = 7'd70;
    bif.rmtWriteReady    = 1'b0;
    @(negedge clk);
    checks++; if (bif.protocolError !== 1'b0) begin errors++; $display("FAIL ovf_err0 got=%b exp=0", bif.protocolError); end
    tick();
    bif.recoveryStart = 1'b0;
    @(negedge clk);
    checks++; if (bif.remainingNum !== 7'd64) begin errors++; $display("FAIL ovf_rem got=%0d exp=64", bif.remainingNum); end
    checks++; if (bif.protocolError !== 1'b1) begin errors++; $display("FAIL ovf_err1 got=%b exp=1", bif.protocolError); end
    checks++; if (bif.popTailNum !== 2'd0) begin errors++; $display("FAIL ovf_stall_pop got=%0d exp=0", bif.popTailNum); end
    bif.rmtWriteReady = 1'b1;
    #1;
    checks++; if (bif.popTailNum !== 2'd2) begin errors++; $display("FAIL ovf_ready_pop got=%0d exp=2", bif.popTailNum); end
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_full();
    test_back_to_back();
    test_start_in_walk();
    test_async_reset();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
